ghost_maze_probe: RTL
=====================

# ghost_maze_probe

Maze-probe block that supplies a ghost controller with its wall-limit flags and current tile coordinates. Once per frame, on `vsync_enable`, it latches the sprite's top-left pixel position and converts it to tile coordinates. It then reads the shared 1-bit wall ROM for the four neighbouring tiles and publishes `up/down/left/right_limit` together, in the same update. One instance sits beside each ghost controller and reuses the board geometry constants.

## Interface
Parameters:
- `H_BOARD_ON`, 200: first horizontal board pixel.
- `V_BOARD_ON`, 40: first vertical board pixel.
- `TILE_SHIFT`, 4: log2 of tile size in pixels (16 px tiles).
- `MAZE_W`, 28: maze width in tiles.
- `MAZE_H`, 31: maze height in tiles.

Ports:
- Clock and reset: one clock `clk`; `reset` is synchronous and active-high.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous active-high reset.
- `vsync_enable`  in  1  one-cycle frame tick; starts a probe.
- `h_sprite_pos`  in  11  sprite top-left horizontal pixel.
- `v_sprite_pos`  in  10  sprite top-left vertical pixel.
- `wall_addr`  out  10  wall ROM address, `{v_tile[4:0], h_tile[4:0]}`.
- `wall_data`  in  1  wall ROM data; 1 = wall; 1-cycle read latency.
- `h_tile`  out  5  current horizontal tile.
- `v_tile`  out  5  current vertical tile.
- `up_limit`, `down_limit`, `left_limit`, `right_limit`  out  1 each  1 = move in that direction is open.
- `limits_valid`  out  1  one-cycle pulse when the outputs above update.

## Operation
- Offsets:
  - `h_rel = h_sprite_pos - H_BOARD_ON`, `v_rel = v_sprite_pos - V_BOARD_ON`, both at 11-bit width.
  - Tile = rel >> TILE_SHIFT; in-tile offset = low TILE_SHIFT bits of rel.
- Horizontal tunnel:
  - `h_sprite_pos < H_BOARD_ON` gives tile 0.
  - Tile ≥ MAZE_W saturates to MAZE_W-1.
  - In both cases the horizontal limits are forced to 1 and the vertical limits to 0, with no ROM reads used for them.
- Vertical saturation: `v_rel` outside 0..MAZE_H*16-1 clamps the tile to 0 or MAZE_H-1.
- Neighbour tiles:
  - Right = h+1 and left = h-1, each wrapping 0 ↔ MAZE_W-1.
  - Up = v-1 and down = v+1; off-maze vertical neighbours count as walls without a ROM read result being used.
- Limit equations:
  - `right_limit = (v_off==0) & ((h_off!=0) | !wall_R)`
  - `left_limit = (v_off==0) & ((h_off!=0) | !wall_L)`
  - `up_limit = (h_off==0) & ((v_off!=0) | !wall_U)`
  - `down_limit = (h_off==0) & ((v_off!=0) | !wall_D)`
- FSM states: IDLE → LATCH → RD_R → RD_L → RD_U → RD_D → DONE → IDLE.
  - IDLE: waits for `vsync_enable`.
  - LATCH: registers position, tiles and offsets.
  - RD_x: drives `wall_addr` for neighbour x. Data for the address driven in cycle n is captured in cycle n+1; the RD_D capture happens in DONE.
  - DONE: computes all four limits, writes the tile and limit outputs in the same cycle, and pulses `limits_valid`.
- `vsync_enable` outside IDLE is ignored; no queueing.
- Position inputs are sampled only in LATCH.

## Timing
- Reset values: all limits 0 (closed), `h_tile`/`v_tile` 0, `limits_valid` 0, `wall_addr` 0, FSM in IDLE.
- Latency: with `vsync_enable` high in cycle 0 (IDLE), the FSM is in LATCH in cycle 1, RD_R..RD_D in cycles 2-5, and DONE in cycle 6. Outputs are updated and `limits_valid` is high from the cycle-6 edge.
- Outputs hold between probes.
- Reset asserted mid-probe: FSM returns to IDLE and all outputs take their reset values on the next edge. Partial results are discarded.
- One probe per frame: 7 cycles, far below the frame period.

## Structure
- Shared package holds:
  - board constants: `H_BOARD_ON`, `V_BOARD_ON`, `MAZE_W`, `MAZE_H`, `TILE_SHIFT`;
  - direction encodings S0-S3 (right, left, down, up), shared with the ghost controllers;
  - the FSM state enum.
- Natural sub-module: `tile_pos_calc` (combinational). It takes pixel position and produces tile, offset, tunnel flag and the four neighbour addresses.
- The wall ROM is external and shared by multiplexing between instances at top level.

## Test plan
- Tile-aligned sprite at pixel (232,72) → tile (2,2). Wall map has a wall at (3,2) only → `right_limit`=0, others 1; `limits_valid` pulses exactly 6 cycles after `vsync_enable`.
- Sprite at (236,72) with `h_off`=4 and the same map → `right_limit`=1, `left_limit`=1, `up_limit`=0, `down_limit`=0.
- `h_sprite_pos`=190 (tunnel) → `h_tile`=0, left=right=1, up=down=0.
- Tile (0,5) aligned with a wall at (27,5) → `left_limit`=0, confirming wrap addressing `wall_addr`=`{5'd5,5'd27}`.
- `reset` in cycle 3 of a probe → limits 0, no `limits_valid` pulse. The next `vsync_enable` completes a full probe normally.
- Second `vsync_enable` in cycle 2 of a probe → ignored; exactly one `limits_valid` pulse.

Source files
------------

// File: rtl/ghost_maze_probe_pkg.sv
// Shared board geometry, direction encodings and probe FSM states for the
// ghost maze-probe block and the ghost controllers around it.
package ghost_maze_probe_pkg;

  localparam int unsigned H_BOARD_ON = 200;
  localparam int unsigned V_BOARD_ON = 40;
  localparam int unsigned TILE_SHIFT = 4;
  localparam int unsigned MAZE_W     = 28;
  localparam int unsigned MAZE_H     = 31;

  // S0 = right, S1 = left, S2 = down, S3 = up
  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } dir_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LATCH = 3'd1,
    RD_R  = 3'd2,
    RD_L  = 3'd3,
    RD_U  = 3'd4,
    RD_D  = 3'd5,
    DONE  = 3'd6
  } state_e;

  function automatic logic [9:0] tile_addr(input logic [4:0] v_tile, input logic [4:0] h_tile);
    return {v_tile, h_tile};
  endfunction

  // Bit n of both vectors is direction n; a tunnel opens only the horizontal moves.
  function automatic logic [3:0] probe_limits(input logic [3:0] walls, input logic h_aligned,
                                              input logic v_aligned, input logic tunnel);
    logic [3:0] lim;
    lim = 4'b0000;
    if (tunnel) begin
      lim[S0] = 1'b1;
      lim[S1] = 1'b1;
    end else begin
      lim[S0] = v_aligned & (!h_aligned | !walls[S0]);
      lim[S1] = v_aligned & (!h_aligned | !walls[S1]);
      lim[S3] = h_aligned & (!v_aligned | !walls[S3]);
      lim[S2] = h_aligned & (!v_aligned | !walls[S2]);
    end
    return lim;
  endfunction

endpackage

// File: rtl/ghost_maze_probe_tile_pos_calc.sv
// Pixel-to-tile conversion: tile, in-tile offset, tunnel flag, vertical edge
// flags and the wall ROM addresses of the four neighbouring tiles.
module ghost_maze_probe_tile_pos_calc #(
  parameter int unsigned H_BOARD_ON = ghost_maze_probe_pkg::H_BOARD_ON,
  parameter int unsigned V_BOARD_ON = ghost_maze_probe_pkg::V_BOARD_ON,
  parameter int unsigned TILE_SHIFT = ghost_maze_probe_pkg::TILE_SHIFT,
  parameter int unsigned MAZE_W     = ghost_maze_probe_pkg::MAZE_W,
  parameter int unsigned MAZE_H     = ghost_maze_probe_pkg::MAZE_H
) (
  input  logic [10:0]           h_pos_i,
  input  logic [9:0]            v_pos_i,
  output logic [4:0]            h_tile_o,
  output logic [4:0]            v_tile_o,
  output logic [TILE_SHIFT-1:0] h_off_o,
  output logic [TILE_SHIFT-1:0] v_off_o,
  output logic                  tunnel_o,
  output logic                  up_edge_o,
  output logic                  down_edge_o,
  output logic [9:0]            addr_r_o,
  output logic [9:0]            addr_l_o,
  output logic [9:0]            addr_u_o,
  output logic [9:0]            addr_d_o
);
  import ghost_maze_probe_pkg::*;

  logic [10:0] h_rel_s, v_rel_s, h_raw_s, v_raw_s;
  logic [4:0]  h_right_s, h_left_s, v_up_s, v_down_s;

  assign h_rel_s = h_pos_i - 11'(H_BOARD_ON);
  assign v_rel_s = {1'b0, v_pos_i} - 11'(V_BOARD_ON);
  assign h_raw_s = h_rel_s >> TILE_SHIFT;
  assign v_raw_s = v_rel_s >> TILE_SHIFT;
  assign h_off_o = h_rel_s[TILE_SHIFT-1:0];
  assign v_off_o = v_rel_s[TILE_SHIFT-1:0];

  // Horizontal tile with tunnel detection on either side of the board
  always_comb begin
    h_tile_o = h_raw_s[4:0];
    tunnel_o = 1'b0;
    if (h_pos_i < 11'(H_BOARD_ON)) begin
      h_tile_o = 5'd0;
      tunnel_o = 1'b1;
    end else if (h_raw_s >= 11'(MAZE_W)) begin
      h_tile_o = 5'(MAZE_W - 1);
      tunnel_o = 1'b1;
    end else begin
      h_tile_o = h_raw_s[4:0];
      tunnel_o = 1'b0;
    end
  end

  // Vertical tile, clamped to the maze rows
  always_comb begin
    v_tile_o = v_raw_s[4:0];
    if (v_pos_i < 10'(V_BOARD_ON)) begin
      v_tile_o = 5'd0;
    end else if (v_raw_s >= 11'(MAZE_H)) begin
      v_tile_o = 5'(MAZE_H - 1);
    end else begin
      v_tile_o = v_raw_s[4:0];
    end
  end

  assign up_edge_o   = (v_tile_o == 5'd0);
  assign down_edge_o = (v_tile_o == 5'(MAZE_H - 1));

  // Neighbour tiles; horizontal wraps, vertical off-maze rows reuse the own row
  always_comb begin
    h_right_s = h_tile_o + 5'd1;
    h_left_s  = h_tile_o - 5'd1;
    v_up_s    = v_tile_o - 5'd1;
    v_down_s  = v_tile_o + 5'd1;
    if (h_tile_o == 5'(MAZE_W - 1)) h_right_s = 5'd0;
    else                            h_right_s = h_tile_o + 5'd1;
    if (h_tile_o == 5'd0) h_left_s = 5'(MAZE_W - 1);
    else                  h_left_s = h_tile_o - 5'd1;
    if (up_edge_o) v_up_s = v_tile_o;
    else           v_up_s = v_tile_o - 5'd1;
    if (down_edge_o) v_down_s = v_tile_o;
    else             v_down_s = v_tile_o + 5'd1;
  end

  assign addr_r_o = tile_addr(v_tile_o, h_right_s);
  assign addr_l_o = tile_addr(v_tile_o, h_left_s);
  assign addr_u_o = tile_addr(v_up_s, h_tile_o);
  assign addr_d_o = tile_addr(v_down_s, h_tile_o);

endmodule

// File: rtl/ghost_maze_probe.sv
// Once-per-frame maze probe: latches the sprite tile, reads the four
// neighbouring walls and publishes all movement limits in one update.
module ghost_maze_probe #(
  parameter int unsigned H_BOARD_ON = ghost_maze_probe_pkg::H_BOARD_ON,
  parameter int unsigned V_BOARD_ON = ghost_maze_probe_pkg::V_BOARD_ON,
  parameter int unsigned TILE_SHIFT = ghost_maze_probe_pkg::TILE_SHIFT,
  parameter int unsigned MAZE_W     = ghost_maze_probe_pkg::MAZE_W,
  parameter int unsigned MAZE_H     = ghost_maze_probe_pkg::MAZE_H
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vsync_enable,
  input  logic [10:0] h_sprite_pos,
  input  logic [9:0]  v_sprite_pos,
  output logic [9:0]  wall_addr,
  input  logic        wall_data,
  output logic [4:0]  h_tile,
  output logic [4:0]  v_tile,
  output logic        up_limit,
  output logic        down_limit,
  output logic        left_limit,
  output logic        right_limit,
  output logic        limits_valid
);
  import ghost_maze_probe_pkg::*;

  state_e state_q, state_d;

  logic [4:0]            calc_h_tile, calc_v_tile;
  logic [TILE_SHIFT-1:0] calc_h_off, calc_v_off;
  logic                  calc_tunnel, calc_up_edge, calc_down_edge;
  logic [9:0]            calc_addr_r, calc_addr_l, calc_addr_u, calc_addr_d;

  logic [4:0] lat_h_tile_q, lat_h_tile_d, lat_v_tile_q, lat_v_tile_d;
  logic       h_aligned_q, h_aligned_d, v_aligned_q, v_aligned_d;
  logic       tunnel_q, tunnel_d, up_edge_q, up_edge_d, down_edge_q, down_edge_d;
  logic [9:0] addr_l_q, addr_l_d, addr_u_q, addr_u_d, addr_dn_q, addr_dn_d;
  logic [3:0] wall_q, wall_d, walls_s;

  logic [9:0] wall_addr_q, wall_addr_d;
  logic [4:0] h_tile_q, h_tile_d, v_tile_q, v_tile_d;
  logic [3:0] limits_q, limits_d;
  logic       valid_q, valid_d;

  ghost_maze_probe_tile_pos_calc #(
    .H_BOARD_ON(H_BOARD_ON), .V_BOARD_ON(V_BOARD_ON), .TILE_SHIFT(TILE_SHIFT),
    .MAZE_W(MAZE_W), .MAZE_H(MAZE_H)
  ) u_calc (
    .h_pos_i(h_sprite_pos), .v_pos_i(v_sprite_pos),
    .h_tile_o(calc_h_tile), .v_tile_o(calc_v_tile),
    .h_off_o(calc_h_off), .v_off_o(calc_v_off),
    .tunnel_o(calc_tunnel), .up_edge_o(calc_up_edge), .down_edge_o(calc_down_edge),
    .addr_r_o(calc_addr_r), .addr_l_o(calc_addr_l),
    .addr_u_o(calc_addr_u), .addr_d_o(calc_addr_d)
  );

  // Next-state, ROM sequencing and output update; ROM data lags its address by one cycle
  always_comb begin
    state_d      = state_q;
    lat_h_tile_d = lat_h_tile_q;
    lat_v_tile_d = lat_v_tile_q;
    h_aligned_d  = h_aligned_q;
    v_aligned_d  = v_aligned_q;
    tunnel_d     = tunnel_q;
    up_edge_d    = up_edge_q;
    down_edge_d  = down_edge_q;
    addr_l_d     = addr_l_q;
    addr_u_d     = addr_u_q;
    addr_dn_d    = addr_dn_q;
    wall_d       = wall_q;
    wall_addr_d  = wall_addr_q;
    h_tile_d     = h_tile_q;
    v_tile_d     = v_tile_q;
    limits_d     = limits_q;
    valid_d      = 1'b0;
    walls_s      = wall_q;
    walls_s[S2]  = down_edge_q | wall_data;
    walls_s[S3]  = up_edge_q | wall_q[S3];
    case (state_q)
      IDLE: begin
        if (vsync_enable) state_d = LATCH;
        else              state_d = IDLE;
      end
      LATCH: begin
        lat_h_tile_d = calc_h_tile;
        lat_v_tile_d = calc_v_tile;
        h_aligned_d  = (calc_h_off == {TILE_SHIFT{1'b0}});
        v_aligned_d  = (calc_v_off == {TILE_SHIFT{1'b0}});
        tunnel_d     = calc_tunnel;
        up_edge_d    = calc_up_edge;
        down_edge_d  = calc_down_edge;
        addr_l_d     = calc_addr_l;
        addr_u_d     = calc_addr_u;
        addr_dn_d    = calc_addr_d;
        wall_addr_d  = calc_addr_r;
        state_d      = RD_R;
      end
      RD_R: begin
        wall_addr_d = addr_l_q;
        state_d     = RD_L;
      end
      RD_L: begin
        wall_d[S0]  = wall_data;
        wall_addr_d = addr_u_q;
        state_d     = RD_U;
      end
      RD_U: begin
        wall_d[S1]  = wall_data;
        wall_addr_d = addr_dn_q;
        state_d     = RD_D;
      end
      RD_D: begin
        wall_d[S3] = wall_data;
        state_d    = DONE;
      end
      DONE: begin
        h_tile_d = lat_h_tile_q;
        v_tile_d = lat_v_tile_q;
        limits_d = probe_limits(walls_s, h_aligned_q, v_aligned_q, tunnel_q);
        valid_d  = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      lat_h_tile_q <= 5'd0;
      lat_v_tile_q <= 5'd0;
      h_aligned_q  <= 1'b0;
      v_aligned_q  <= 1'b0;
      tunnel_q     <= 1'b0;
      up_edge_q    <= 1'b0;
      down_edge_q  <= 1'b0;
      addr_l_q     <= 10'd0;
      addr_u_q     <= 10'd0;
      addr_dn_q    <= 10'd0;
      wall_q       <= 4'd0;
      wall_addr_q  <= 10'd0;
      h_tile_q     <= 5'd0;
      v_tile_q     <= 5'd0;
      limits_q     <= 4'd0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      lat_h_tile_q <= lat_h_tile_d;
      lat_v_tile_q <= lat_v_tile_d;
      h_aligned_q  <= h_aligned_d;
      v_aligned_q  <= v_aligned_d;
      tunnel_q     <= tunnel_d;
      up_edge_q    <= up_edge_d;
      down_edge_q  <= down_edge_d;
      addr_l_q     <= addr_l_d;
      addr_u_q     <= addr_u_d;
      addr_dn_q    <= addr_dn_d;
      wall_q       <= wall_d;
      wall_addr_q  <= wall_addr_d;
      h_tile_q     <= h_tile_d;
      v_tile_q     <= v_tile_d;
      limits_q     <= limits_d;
      valid_q      <= valid_d;
    end
  end

  assign wall_addr    = wall_addr_q;
  assign h_tile       = h_tile_q;
  assign v_tile       = v_tile_q;
  assign right_limit  = limits_q[S0];
  assign left_limit   = limits_q[S1];
  assign down_limit   = limits_q[S2];
  assign up_limit     = limits_q[S3];
  assign limits_valid = valid_q;

endmodule
